wishbone_apb_bridge: RTL and testbench

Wishbone classic slave to AMBA APB master bridge. It runs in the opposite direction to the existing APB-to-Wishbone bridge in front of the Ethernet MAC. It lets a Wishbone master, such as a MAC DMA port or a debug master, reach APB peripherals. Each Wishbone cycle becomes exactly one APB transfer, with registered outputs on both sides.

---
 rtl/wishbone_apb_bridge.sv | 105 ++++++++++
 tb/tb_wishbone_apb_bridge.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wishbone_apb_bridge.sv
// wishbone_apb_bridge: Wishbone classic slave to APB master, one APB transfer per Wishbone cycle.
// Define WB2APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT cycles without PREADY.
module wishbone_apb_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 255
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    CYC_I,
   input  logic                    STB_I,
   input  logic                    WE_I,
   input  logic [ADDR_WIDTH-1:0]   ADR_I,
   input  logic [DATA_WIDTH/8-1:0] SEL_I,
   input  logic [DATA_WIDTH-1:0]   DAT_I,
   output logic [DATA_WIDTH-1:0]   DAT_O,
   output logic                    ACK_O,
   output logic                    ERR_O,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t state;
   logic   abort;
   logic   abort_now;
   logic   expired;
   if (DATA_WIDTH % 8 != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("wishbone_apb_bridge: DATA_WIDTH must be a multiple of 8 and TIMEOUT at least 1");
   end
   // a master dropping CYC_I this cycle counts as aborted immediately
   assign abort_now = abort | ~CYC_I;
`ifdef WB2APB_TIMEOUT_EN
   localparam int CB = $clog2(TIMEOUT + 1);
   localparam int CW = CB < 8 ? 8 : (CB > 16 ? 16 : CB);
   logic [CW-1:0] cnt;
   assign expired = ~PREADY && (cnt == CW'(TIMEOUT - 1));
`else
   assign expired = 1'b0;
`endif
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         abort   <= 1'b0;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PADDR   <= '0;
         PWRITE  <= 1'b0;
         PWDATA  <= '0;
         PSTRB   <= '0;
         DAT_O   <= '0;
         ACK_O   <= 1'b0;
         ERR_O   <= 1'b0;
`ifdef WB2APB_TIMEOUT_EN
         cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (CYC_I && STB_I) begin
               PADDR  <= ADR_I;
               PWRITE <= WE_I;
               PWDATA <= DAT_I;
               PSTRB  <= WE_I ? SEL_I : '0;
               abort  <= 1'b0;
               PSEL   <= 1'b1;
               state  <= SETUP;
`ifdef WB2APB_TIMEOUT_EN
               cnt    <= '0;
`endif
            end
            SETUP: begin
               abort   <= abort_now;
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               abort <= abort_now;
`ifdef WB2APB_TIMEOUT_EN
               if (!PREADY) cnt <= cnt + 1'b1;
`endif
               // the APB transfer always runs to completion; abort only hides the response
               if (PREADY || expired) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PREADY && !PWRITE) DAT_O <= PRDATA;
                  ACK_O   <= PREADY & ~PSLVERR & ~abort_now;
                  ERR_O   <= (~PREADY | PSLVERR) & ~abort_now;
                  state   <= abort_now ? IDLE : RESP;
               end
            end
            RESP: begin
               ACK_O <= 1'b0;
               ERR_O <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wishbone_apb_bridge.sv
// tb_wishbone_apb_bridge: randomized Wishbone-to-APB transfers against a transaction-level model.
module tb_wishbone_apb_bridge;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [9:0]  adr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat_i = '0, dat_o, pwdata, prdata = '0;
   logic        ack_o, err_o, psel, penable, pwrite;
   logic [9:0]  paddr;
   logic [3:0]  pstrb;
   logic        pready = 1'b0, pslverr = 1'b0;
   int          checks = 0, failures = 0;
   logic [31:0] exp_dat = '0;
   bit          dat_known = 1'b1;

   wishbone_apb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT(8)) dut (
      .PCLK(pclk), .PRESETn(presetn), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
      .SEL_I(sel), .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack_o), .ERR_O(err_o),
      .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check(tag, {psel, penable, ack_o, err_o}, 4'b0000);
   endtask

   // One Wishbone cycle; request presented in cycle 0, response expected in cycle 3+waits.
   task automatic txn(input bit w, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d,
                      input int waits, input bit e, input bit ab, input logic [31:0] rd);
      cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d; pready = 0; pslverr = 0;
      tick();
      check("setup_phase", {psel, penable, ack_o, err_o}, 4'b1000);
      check("paddr", paddr, a);
      check("pwrite", pwrite, w);
      check("pstrb", pstrb, w ? s : 4'h0);
      if (w) check("pwdata", pwdata, d);
      if (ab) begin cyc = 0; stb = 0; end
      tick();
      for (int i = 0; i <= waits; i++) begin
         check("access_phase", {psel, penable, ack_o, err_o}, 4'b1100);
         check("paddr_stable", paddr, a);
         if (i == waits) begin pready = 1; pslverr = e; prdata = rd; end
         tick();
      end
      if (!w && !ab) begin exp_dat = rd; dat_known = 1; end
      if (!w && ab) dat_known = 0;
      check("response", {psel, penable, ack_o, err_o}, {2'b00, !ab && !e, !ab && e});
      if (dat_known) check("dat_o", dat_o, exp_dat);
      cyc = 0; stb = 0; pready = 0; pslverr = 0;
      tick();
      check_idle_outputs("after_response");
   endtask

   initial begin
      logic [9:0]  b2b_adr [4];
      logic [31:0] b2b_dat [4];
      int          acks;
      repeat (3) tick();
      check("reset_ctrl", {psel, penable, ack_o, err_o, pwrite}, 5'b0);
      check("reset_bus", {paddr, pstrb, pwdata, dat_o}, '0);
      @(negedge pclk) presetn = 1;
      tick();
      check_idle_outputs("idle_after_reset");

      txn(1, 10'h155, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      txn(0, 10'h0A3, 4'hF, 32'hFFFFFFFF, 3, 0, 0, 32'h12345678);
      txn(0, 10'h3FF, 4'h3, 32'h0, 1, 1, 0, 32'hCAFEF00D);
      txn(1, 10'h200, 4'h0, 32'h0BADC0DE, 0, 0, 0, 32'h0);
      txn(1, 10'h011, 4'h5, 32'h11111111, 2, 0, 1, 32'h0);
      txn(0, 10'h022, 4'hF, 32'h0, 0, 0, 1, 32'h55AA55AA);
      txn(0, 10'h033, 4'hF, 32'h0, 0, 0, 0, 32'hA5A5A5A5);

      for (int n = 0; n < 40; n++)
         txn($urandom % 2, 10'($urandom), 4'($urandom), $urandom, $urandom_range(0, 4),
             ($urandom % 4) == 0, ($urandom % 6) == 0, $urandom);

      // back-to-back writes with STB held: one transfer per 4 cycles
      for (int k = 0; k < 4; k++) begin b2b_adr[k] = 10'($urandom); b2b_dat[k] = $urandom; end
      acks = 0;
      cyc = 1; stb = 1; we = 1; sel = 4'hF; pready = 1; adr = b2b_adr[0]; dat_i = b2b_dat[0];
      for (int t = 1; t <= 16; t++) begin
         tick();
         check("b2b_phase", {psel, penable, ack_o}, {(t % 4 == 1) || (t % 4 == 2), t % 4 == 2, t % 4 == 3});
         if (ack_o) acks++;
         if (t % 4 == 1) begin
            check("b2b_paddr", paddr, b2b_adr[t / 4]);
            check("b2b_pwdata", pwdata, b2b_dat[t / 4]);
         end
         if (t % 4 == 3) begin
            if (t / 4 + 1 < 4) begin adr = b2b_adr[t / 4 + 1]; dat_i = b2b_dat[t / 4 + 1]; end
            else begin cyc = 0; stb = 0; end
         end
      end
      check("b2b_ack_count", acks, 4);
      pready = 0;
      tick();

`ifdef WB2APB_TIMEOUT_EN
      cyc = 1; stb = 1; we = 0; adr = 10'h2AA; sel = 4'hF; pready = 0; prdata = 32'h77777777;
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         check("timeout_wait", {psel, penable, ack_o, err_o}, 4'b1100);
         tick();
      end
      check("timeout_err", {psel, penable, ack_o, err_o}, 4'b0001);
      if (dat_known) check("timeout_dat_o", dat_o, exp_dat);
      cyc = 0; stb = 0;
      tick();
      check_idle_outputs("timeout_after");
`endif

      // reset asserted mid-ACCESS clears outputs without waiting for a clock edge
      cyc = 1; stb = 1; we = 1; adr = 10'h1C3; sel = 4'hA; dat_i = 32'h13579BDF; pready = 0;
      tick();
      tick();
      tick();
      check("pre_reset_access", {psel, penable}, 2'b11);
      #2 presetn = 0;
      #1;
      check("async_reset_ctrl", {psel, penable, ack_o, err_o, pwrite}, 5'b0);
      check("async_reset_bus", {paddr, pstrb, pwdata, dat_o}, '0);
      cyc = 0; stb = 0;
      @(negedge pclk) presetn = 1;
      tick();
      check_idle_outputs("idle_after_async_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
